// File: rtl/cache_flush_engine_pkg.sv
// -----------------------------------------------------------------------------
// cache_flush_engine_pkg
// Shared definitions for the cache flush engine: flag bit positions stored
// alongside each tag, and the flush sequencer state encoding.
// -----------------------------------------------------------------------------
package cache_flush_engine_pkg;

    localparam int FLAG_VALID = 0;
    localparam int FLAG_DIRTY = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CHK,
        WB_REQ,
        WB_RESP,
        INV,
        NEXT,
        DONE
    } flush_state_e;

endpackage

// File: rtl/cache_flush_engine_if.sv
// -----------------------------------------------------------------------------
// cache_flush_engine_if
// Bundles the three buses around the flush engine:
//   flush command : i_flush_valid/all/addr -> o_flush_ready/end/err
//   line memory   : o_mem_addr/wstrb/wdata/wflags -> i_mem_raddr/rdata/rflags/hit
//   writeback bus : o_req_valid/addr/data <- i_req_ready, i_resp_valid/err
// Signal names carry the engine's point of view. The master modport is the
// engine; the slave modport is the cache controller, memory and bus side.
// -----------------------------------------------------------------------------
interface cache_flush_engine_if #(
    parameter int abus   = 64,
    parameter int lnbits = 5,
    parameter int flbits = 4
);
    localparam int L = 8 * (2 ** lnbits);

    logic                 i_flush_valid;
    logic                 i_flush_all;
    logic [abus-1:0]      i_flush_addr;
    logic                 o_flush_ready;
    logic                 o_flush_end;
    logic                 o_flush_err;

    logic [abus-1:0]      o_mem_addr;
    logic [2**lnbits-1:0] o_mem_wstrb;
    logic [L-1:0]         o_mem_wdata;
    logic [flbits-1:0]    o_mem_wflags;
    logic [abus-1:0]      i_mem_raddr;
    logic [L-1:0]         i_mem_rdata;
    logic [flbits-1:0]    i_mem_rflags;
    logic                 i_mem_hit;

    logic                 o_req_valid;
    logic                 i_req_ready;
    logic [abus-1:0]      o_req_addr;
    logic [L-1:0]         o_req_data;
    logic                 i_resp_valid;
    logic                 i_resp_err;

    modport master (
        input  i_flush_valid, i_flush_all, i_flush_addr,
        output o_flush_ready, o_flush_end, o_flush_err,
        output o_mem_addr, o_mem_wstrb, o_mem_wdata, o_mem_wflags,
        input  i_mem_raddr, i_mem_rdata, i_mem_rflags, i_mem_hit,
        output o_req_valid, o_req_addr, o_req_data,
        input  i_req_ready, i_resp_valid, i_resp_err
    );

    modport slave (
        output i_flush_valid, i_flush_all, i_flush_addr,
        input  o_flush_ready, o_flush_end, o_flush_err,
        input  o_mem_addr, o_mem_wstrb, o_mem_wdata, o_mem_wflags,
        output i_mem_raddr, i_mem_rdata, i_mem_rflags, i_mem_hit,
        input  o_req_valid, o_req_addr, o_req_data,
        output i_req_ready, i_resp_valid, i_resp_err
    );

endinterface

// File: rtl/cache_flush_engine.sv
// -----------------------------------------------------------------------------
// cache_flush_engine
// Walks one cache line (single-address flush) or every line index (flush-all),
// writes each valid+dirty line back over the bus, then invalidates it with a
// tag write. A bus error on a writeback leaves that line in place and sets a
// sticky error flag that clears on the next accepted command.
//
// Ports:
//   i_clk   : clock
//   i_nrst  : asynchronous active-low reset
//   bus     : cache_flush_engine_if.master (command, line memory, writeback bus)
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | ready for a command
// RD      | present tag/index to the line memory
// CHK     | memory outputs valid; decide writeback / invalidate / skip
// WB_REQ  | writeback request held on the bus until accepted
// WB_RESP | waiting for the writeback response
// INV     | one-cycle tag write clearing the line flags
// NEXT    | advance index (flush-all) or finish
// DONE    | one-cycle completion pulse
// -----------------------------------------------------------------------------
module cache_flush_engine
    import cache_flush_engine_pkg::*;
#(
    parameter int async_reset = 1,
    parameter int abus        = 64,
    parameter int ibits       = 6,
    parameter int lnbits      = 5,
    parameter int flbits      = 4
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    cache_flush_engine_if.master bus
);

    localparam int L  = 8 * (2 ** lnbits);
    localparam int TW = abus - ibits - lnbits;

    flush_state_e   r_state, w_state_nxt;
    logic           r_all, w_all_nxt;
    logic [TW-1:0]  r_tag, w_tag_nxt;
    logic [ibits-1:0] r_idx, w_idx_nxt;
    logic [abus-1:0] r_line_addr, w_line_addr_nxt;
    logic [L-1:0]   r_line_data, w_line_data_nxt;
    logic           r_err, w_err_nxt;

    logic           w_sel;
    logic           w_arst_n;
    logic           w_srst_n;
    logic           w_unused;

    // The block is built for async reset; the synchronous path only exists so
    // that a zero setting still yields a working (sync-reset) register set.
    assign w_arst_n = (async_reset != 0) ? i_nrst : 1'b1;
    assign w_srst_n = (async_reset != 0) ? 1'b1 : i_nrst;

    // Flush-all ignores the tag compare and takes any valid line.
    assign w_sel = r_all ? bus.i_mem_rflags[FLAG_VALID] : bus.i_mem_hit;

    // Index and offset bits of the returned address are replaced locally.
    assign w_unused = ^{bus.i_mem_raddr[ibits+lnbits-1:0], bus.i_mem_rflags};

    assign bus.o_flush_err = r_err;
    assign bus.o_req_addr  = r_line_addr;
    assign bus.o_req_data  = r_line_data;

    always_ff @(posedge i_clk or negedge w_arst_n) begin
        if (!w_arst_n) begin
            r_state     <= IDLE;
            r_all       <= 1'b0;
            r_tag       <= '0;
            r_idx       <= '0;
            r_line_addr <= '0;
            r_line_data <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_all       <= w_all_nxt;
            r_tag       <= w_tag_nxt;
            r_idx       <= w_idx_nxt;
            r_line_addr <= w_line_addr_nxt;
            r_line_data <= w_line_data_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_all_nxt       = r_all;
        w_tag_nxt       = r_tag;
        w_idx_nxt       = r_idx;
        w_line_addr_nxt = r_line_addr;
        w_line_data_nxt = r_line_data;
        w_err_nxt       = r_err;

        bus.o_flush_ready = 1'b0;
        bus.o_flush_end   = 1'b0;
        bus.o_mem_addr    = '0;
        bus.o_mem_wstrb   = '0;
        bus.o_mem_wdata   = '0;
        bus.o_mem_wflags  = '0;
        bus.o_req_valid   = 1'b0;

        case (r_state)
            IDLE: begin
                bus.o_flush_ready = 1'b1;
                if (bus.i_flush_valid) begin
                    w_all_nxt   = bus.i_flush_all;
                    w_tag_nxt   = bus.i_flush_addr[abus-1:ibits+lnbits];
                    w_idx_nxt   = bus.i_flush_all ? '0
                                : bus.i_flush_addr[ibits+lnbits-1:lnbits];
                    w_err_nxt   = 1'b0;
                    w_state_nxt = RD;
                end
            end
            RD: begin
                bus.o_mem_addr = {r_tag, r_idx, {lnbits{1'b0}}};
                w_state_nxt    = CHK;
            end
            CHK: begin
                if (w_sel) begin
                    // Line address is kept for the invalidate even on clean lines.
                    w_line_addr_nxt = {bus.i_mem_raddr[abus-1:ibits+lnbits], r_idx,
                                       {lnbits{1'b0}}};
                    if (bus.i_mem_rflags[FLAG_DIRTY]) begin
                        w_line_data_nxt = bus.i_mem_rdata;
                        w_state_nxt     = WB_REQ;
                    end else begin
                        w_state_nxt = INV;
                    end
                end else begin
                    w_state_nxt = NEXT;
                end
            end
            WB_REQ: begin
                bus.o_req_valid = 1'b1;
                if (bus.i_req_ready) begin
                    w_state_nxt = WB_RESP;
                end
            end
            WB_RESP: begin
                if (bus.i_resp_valid) begin
                    if (bus.i_resp_err) begin
                        // Keep the line: its data never reached memory.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = NEXT;
                    end else begin
                        w_state_nxt = INV;
                    end
                end
            end
            INV: begin
                bus.o_mem_addr  = r_line_addr;
                bus.o_mem_wstrb = '1;
                w_state_nxt     = NEXT;
            end
            NEXT: begin
                if (!r_all || (r_idx == '1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt   = r_idx + ibits'(1);
                    w_state_nxt = RD;
                end
            end
            DONE: begin
                bus.o_flush_end = 1'b1;
                w_state_nxt     = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (!w_srst_n) begin
            w_state_nxt     = IDLE;
            w_all_nxt       = 1'b0;
            w_tag_nxt       = '0;
            w_idx_nxt       = '0;
            w_line_addr_nxt = '0;
            w_line_data_nxt = '0;
            w_err_nxt       = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_flush_engine.sv
module tb_cache_flush_engine;

    localparam int ABUS   = 64;
    localparam int IBITS  = 2;
    localparam int LNBITS = 5;
    localparam int FLBITS = 4;
    localparam int LW     = 8 * (2 ** LNBITS);
    localparam int NL     = 2 ** IBITS;
    localparam int TW     = ABUS - IBITS - LNBITS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_flush_engine_if #(.abus(ABUS), .lnbits(LNBITS), .flbits(FLBITS)) bus_if ();

    cache_flush_engine #(
        .async_reset(1), .abus(ABUS), .ibits(IBITS), .lnbits(LNBITS), .flbits(FLBITS)
    ) dut (
        .i_clk  (clk),
        .i_nrst (rst_n),
        .bus    (bus_if.master)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // line memory contents (written only by the stimulus block)
    logic [TW-1:0]     m_tag   [NL];
    logic [FLBITS-1:0] m_flags [NL];
    logic [LW-1:0]     m_data  [NL];

    // bus configuration (written only by the stimulus block)
    int         bus_stall  = 0;
    int         resp_delay = 0;
    logic [NL-1:0] err_mask = '0;

    // monitor logs
    int              inv_log[$];
    int              inv_bad  = 0;
    logic [ABUS-1:0] wb_addr_q[$];
    logic [LW-1:0]   wb_data_q[$];
    int              wb_vcyc_q[$];
    int              unstable = 0;
    int              end_cnt  = 0;
    int              end_cyc  = 0;

    // expectations from the reference model
    logic [ABUS-1:0] exp_wb_addr[$];
    logic [LW-1:0]   exp_wb_data[$];
    int              exp_inv[$];
    bit              exp_err;
    int              lat;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.o_flush_end) begin
            end_cnt = end_cnt + 1;
            end_cyc = cyc;
        end
    end

    // Line memory: one-cycle read latency, logs every write.
    always @(posedge clk) begin : mem_model
        int idx;
        idx = int'(bus_if.o_mem_addr[IBITS+LNBITS-1:LNBITS]);
        bus_if.i_mem_raddr  <= {m_tag[idx], bus_if.o_mem_addr[IBITS+LNBITS-1:LNBITS], {LNBITS{1'b0}}};
        bus_if.i_mem_rdata  <= m_data[idx];
        bus_if.i_mem_rflags <= m_flags[idx];
        bus_if.i_mem_hit    <= (m_tag[idx] == bus_if.o_mem_addr[ABUS-1:IBITS+LNBITS]) && m_flags[idx][0];
        if (bus_if.o_mem_wstrb != '0) begin
            if (bus_if.o_mem_wstrb != '1 || bus_if.o_mem_wdata != '0 ||
                bus_if.o_mem_wflags != '0 || bus_if.o_mem_addr[LNBITS-1:0] != '0)
                inv_bad = inv_bad + 1;
            inv_log.push_back(idx);
        end
    end

    // Writeback bus: stalls bus_stall cycles, answers resp_delay cycles after
    // the cycle following the handshake, errors by line index via err_mask.
    logic [ABUS-1:0] p_addr;
    logic [LW-1:0]   p_data;
    int  vcyc = 0, resp_wait = 0;
    bit  pend = 0, have_prev = 0, pend_err = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus_if.i_req_ready  = 1'b0;
            bus_if.i_resp_valid = 1'b0;
            bus_if.i_resp_err   = 1'b0;
            pend = 0; have_prev = 0; vcyc = 0;
        end else begin
            bus_if.i_resp_valid = 1'b0;
            bus_if.i_resp_err   = 1'b0;
            if (bus_if.i_req_ready) begin
                bus_if.i_req_ready = 1'b0;
                wb_addr_q.push_back(p_addr);
                wb_data_q.push_back(p_data);
                wb_vcyc_q.push_back(vcyc);
                pend      = 1;
                resp_wait = resp_delay;
                pend_err  = err_mask[p_addr[IBITS+LNBITS-1:LNBITS]];
                have_prev = 0;
                vcyc      = 0;
            end else if (bus_if.o_req_valid) begin
                vcyc = vcyc + 1;
                if (have_prev && (bus_if.o_req_addr != p_addr || bus_if.o_req_data != p_data))
                    unstable = unstable + 1;
                p_addr    = bus_if.o_req_addr;
                p_data    = bus_if.o_req_data;
                have_prev = 1;
                if (vcyc > bus_stall) bus_if.i_req_ready = 1'b1;
            end
            if (pend) begin
                if (resp_wait == 0) begin
                    bus_if.i_resp_valid = 1'b1;
                    bus_if.i_resp_err   = pend_err;
                    pend = 0;
                end else begin
                    resp_wait = resp_wait - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic load_line(input int i, input logic [TW-1:0] t, input logic [FLBITS-1:0] f);
        m_tag[i]   = t;
        m_flags[i] = f;
        m_data[i]  = rand_line();
    endtask

    // Reference: which lines get written back, which get invalidated.
    task automatic model(input bit all, input logic [ABUS-1:0] addr);
        int lo, hi;
        bit sel;
        logic [ABUS-1:0] la;
        exp_wb_addr.delete();
        exp_wb_data.delete();
        exp_inv.delete();
        exp_err = 0;
        lo = all ? 0 : int'(addr[IBITS+LNBITS-1:LNBITS]);
        hi = all ? NL - 1 : lo;
        for (int i = lo; i <= hi; i++) begin
            sel = all ? m_flags[i][0]
                      : (m_flags[i][0] && m_tag[i] == addr[ABUS-1:IBITS+LNBITS]);
            if (sel) begin
                if (m_flags[i][1]) begin
                    la = {m_tag[i], IBITS'(i), {LNBITS{1'b0}}};
                    exp_wb_addr.push_back(la);
                    exp_wb_data.push_back(m_data[i]);
                end
                if (m_flags[i][1] && err_mask[i]) exp_err = 1;
                else exp_inv.push_back(i);
            end
        end
    endtask

    task automatic run_cmd(input bit all, input logic [ABUS-1:0] addr, input string nm);
        int wb0, inv0, end0, bad0, uns0, c0, waited, nwb, ninv;
        wb0 = wb_addr_q.size(); inv0 = inv_log.size(); end0 = end_cnt;
        bad0 = inv_bad; uns0 = unstable;
        model(all, addr);
        @(negedge clk);
        chk({nm, " ready"}, LW'(bus_if.o_flush_ready), LW'(1'b1));
        bus_if.i_flush_valid = 1'b1;
        bus_if.i_flush_all   = all;
        bus_if.i_flush_addr  = addr;
        c0 = cyc;
        @(negedge clk);
        bus_if.i_flush_valid = 1'b0;
        chk({nm, " err cleared"}, LW'(bus_if.o_flush_err), LW'(1'b0));
        waited = 0;
        while (end_cnt == end0 && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        chk({nm, " completes"}, LW'(end_cnt != end0), LW'(1'b1));
        lat = end_cyc - c0;
        repeat (3) @(negedge clk);
        chk({nm, " end pulses"}, LW'(end_cnt - end0), LW'(1));
        chk({nm, " ready after"}, LW'(bus_if.o_flush_ready), LW'(1'b1));
        chk({nm, " err"}, LW'(bus_if.o_flush_err), LW'(exp_err));
        nwb  = wb_addr_q.size() - wb0;
        ninv = inv_log.size() - inv0;
        chk({nm, " wb count"}, LW'(nwb), LW'(exp_wb_addr.size()));
        for (int k = 0; k < nwb && k < exp_wb_addr.size(); k++) begin
            chk({nm, " wb addr"}, LW'(wb_addr_q[wb0+k]), LW'(exp_wb_addr[k]));
            chk({nm, " wb data"}, wb_data_q[wb0+k], exp_wb_data[k]);
        end
        chk({nm, " inv count"}, LW'(ninv), LW'(exp_inv.size()));
        for (int k = 0; k < ninv && k < exp_inv.size(); k++)
            chk({nm, " inv index"}, LW'(inv_log[inv0+k]), LW'(exp_inv[k]));
        chk({nm, " inv fields"}, LW'(inv_bad - bad0), LW'(0));
        chk({nm, " req stable"}, LW'(unstable - uns0), LW'(0));
    endtask

    initial begin : stim
        logic [ABUS-1:0] a;
        logic [TW-1:0] ta, tb;
        int end0, inv0, waited;

        bus_if.i_flush_valid = 1'b0;
        bus_if.i_flush_all   = 1'b0;
        bus_if.i_flush_addr  = '0;
        ta = TW'({$urandom(), $urandom()});
        tb = ~ta;
        for (int i = 0; i < NL; i++) load_line(i, ta, 4'b0000);

        // reset state
        repeat (3) @(negedge clk);
        chk("reset ready", LW'(bus_if.o_flush_ready), LW'(1'b1));
        chk("reset end", LW'(bus_if.o_flush_end), LW'(1'b0));
        chk("reset err", LW'(bus_if.o_flush_err), LW'(1'b0));
        chk("reset req_valid", LW'(bus_if.o_req_valid), LW'(1'b0));
        chk("reset wstrb", LW'(bus_if.o_mem_wstrb), LW'(0));
        chk("reset mem_addr", LW'(bus_if.o_mem_addr), LW'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single flush, dirty hit
        a = 64'h8000_1040;
        load_line(2, a[ABUS-1:IBITS+LNBITS], 4'b0011);
        run_cmd(1'b0, a, "single dirty");
        if (wb_addr_q.size() > 0)
            chk("single dirty req_addr", LW'(wb_addr_q[wb_addr_q.size()-1]), LW'(64'h8000_1040));

        // single flush, miss
        load_line(0, ta, 4'b0011);
        run_cmd(1'b0, {tb, 2'd0, 5'd0}, "single miss");
        chk("single miss latency", LW'(lat), LW'(4));

        // flush-all, dirty at 1 and 3
        load_line(0, ta, 4'b0001);
        load_line(1, tb, 4'b0011);
        load_line(2, ta, 4'b0000);
        load_line(3, ta, 4'b0011);
        run_cmd(1'b1, '0, "flush all");

        // bus stall of 5 cycles
        bus_stall = 5;
        load_line(1, ta, 4'b0011);
        run_cmd(1'b0, {ta, 2'd1, 5'd3}, "stall");
        chk("stall handshake cycle", LW'(wb_vcyc_q[wb_vcyc_q.size()-1]), LW'(6));
        bus_stall = 0;

        // writeback error, then a clean command clears the flag
        err_mask = 4'b1000;
        load_line(3, tb, 4'b0011);
        run_cmd(1'b0, {tb, 2'd3, 5'd0}, "resp err");
        err_mask = '0;
        load_line(1, ta, 4'b0001);
        run_cmd(1'b0, {ta, 2'd1, 5'd0}, "after err");

        // reset while a writeback request is pending
        bus_stall = 1000;
        load_line(2, ta, 4'b0011);
        end0 = end_cnt;
        inv0 = inv_log.size();
        @(negedge clk);
        bus_if.i_flush_valid = 1'b1;
        bus_if.i_flush_all   = 1'b0;
        bus_if.i_flush_addr  = {ta, 2'd2, 5'd0};
        @(negedge clk);
        bus_if.i_flush_valid = 1'b0;
        waited = 0;
        while (!bus_if.o_req_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("rst req seen", LW'(bus_if.o_req_valid), LW'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("rst req_valid", LW'(bus_if.o_req_valid), LW'(1'b0));
        chk("rst req_addr", LW'(bus_if.o_req_addr), LW'(0));
        chk("rst req_data", bus_if.o_req_data, LW'(0));
        chk("rst wstrb", LW'(bus_if.o_mem_wstrb), LW'(0));
        chk("rst end", LW'(bus_if.o_flush_end), LW'(1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_stall = 0;
        repeat (10) @(negedge clk);
        chk("rst ready", LW'(bus_if.o_flush_ready), LW'(1'b1));
        chk("rst no end", LW'(end_cnt - end0), LW'(0));
        chk("rst no inv", LW'(inv_log.size() - inv0), LW'(0));

        // randomized commands
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < NL; i++)
                load_line(i, ($urandom_range(0, 1) != 0) ? ta : tb, FLBITS'($urandom_range(0, 15)));
            bus_stall  = $urandom_range(0, 3);
            resp_delay = $urandom_range(0, 2);
            err_mask   = NL'($urandom_range(0, 15) & $urandom_range(0, 15));
            a = {(($urandom_range(0, 1) != 0) ? ta : tb), IBITS'($urandom_range(0, NL-1)),
                 LNBITS'($urandom())};
            run_cmd($urandom_range(0, 1) != 0, a, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
